// File: rtl/uart_tx_pull.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_pull
//  Purpose  : UART transmitter that pulls words from an upstream FIFO
//             (first-word-fall-through head). Frames consist of one start
//             bit, dataBits payload bits LSB first, an optional parity bit
//             and one or two stop bits. A new word is popped in the last
//             cycle of the final stop bit, so queued words go out
//             back-to-back with no idle gap.
//  Ports    : clk     - rising-edge clock
//             reset   - asynchronous active-low reset
//             fifoE   - upstream FIFO empty flag (1 = no word available)
//             dataIn  - upstream FIFO head word, valid while fifoE = 0
//             readEn  - pop strobe to the FIFO, one clk per consumed word
//             tx      - registered serial output, idles high
//             txBusy  - high from the first START cycle to the last STOP cycle
//             txDone  - one-clk pulse after a frame that is not followed
//                       by another
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_pull #(
    parameter int dataBits   = 8,
    parameter int clksPerBit = 868,
    parameter int parityMode = 0,
    parameter int stopBits   = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                fifoE,
    input  logic [dataBits-1:0] dataIn,
    output logic                readEn,
    output logic                tx,
    output logic                txBusy,
    output logic                txDone
);

    localparam int TW = $clog2(clksPerBit);
    localparam int BW = (dataBits > 1) ? $clog2(dataBits) : 1;

    localparam logic [TW-1:0] c_TICK_MAX   = TW'(clksPerBit - 1);
    localparam logic [BW-1:0] c_BIT_MAX    = BW'(dataBits - 1);
    localparam logic          c_STOP_MAX   = (stopBits == 2);
    localparam logic          c_HAS_PARITY = (parityMode != 0);
    localparam logic          c_ODD        = (parityMode == 2);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                state_q,  state_d;
    logic [TW-1:0]         tick_q,   tick_d;
    logic [BW-1:0]         bit_q,    bit_d;
    logic                  stop_q,   stop_d;
    logic [dataBits-1:0]   shreg_q,  shreg_d;
    logic                  par_q,    par_d;
    logic                  tx_q,     tx_d;
    logic                  busy_q,   busy_d;
    logic                  done_q,   done_d;

    logic                  w_tick_end;
    logic                  w_last_stop;
    logic [dataBits-1:0]   w_shifted;

    assign w_tick_end  = (tick_q == c_TICK_MAX);
    assign w_last_stop = (state_q == S_STOP) && w_tick_end && (stop_q == c_STOP_MAX);
    assign w_shifted   = shreg_q >> 1;

    // Pop whenever a word is waiting and the line is free on the next edge:
    // either idle, or the very last cycle of the final stop bit. Gating with
    // the raw reset input keeps the FIFO untouched while reset is held.
    assign readEn = ~fifoE & reset & ((state_q == S_IDLE) | w_last_stop);

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        stop_d  = stop_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        if (state_q != S_IDLE) begin
            tick_d = w_tick_end ? '0 : tick_q + TW'(1);
        end

        case (state_q)
            S_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (readEn) begin
                    state_d = S_START;
                    tick_d  = '0;
                    bit_d   = '0;
                    stop_d  = 1'b0;
                    shreg_d = dataIn;
                    par_d   = (^dataIn) ^ c_ODD;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            S_START: begin
                if (w_tick_end) begin
                    state_d = S_DATA;
                    tx_d    = shreg_q[0];
                end
            end
            S_DATA: begin
                if (w_tick_end) begin
                    if (bit_q == c_BIT_MAX) begin
                        if (c_HAS_PARITY) begin
                            state_d = S_PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = S_STOP;
                            stop_d  = 1'b0;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d   = bit_q + BW'(1);
                        shreg_d = w_shifted;
                        tx_d    = w_shifted[0];
                    end
                end
            end
            S_PARITY: begin
                if (w_tick_end) begin
                    state_d = S_STOP;
                    stop_d  = 1'b0;
                    tx_d    = 1'b1;
                end
            end
            S_STOP: begin
                if (w_tick_end) begin
                    if (stop_q == c_STOP_MAX) begin
                        if (readEn) begin
                            // Back-to-back frame: start bit on the next clk.
                            state_d = S_START;
                            tick_d  = '0;
                            bit_d   = '0;
                            stop_d  = 1'b0;
                            shreg_d = dataIn;
                            par_d   = (^dataIn) ^ c_ODD;
                            tx_d    = 1'b0;
                            busy_d  = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                            tx_d    = 1'b1;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                    end else begin
                        stop_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tick_d  = '0;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tx     = tx_q;
    assign txBusy = busy_q;
    assign txDone = done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_pull.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_pull
//  Purpose  : Self-checking bench for uart_tx_pull. Four instances cover
//             no parity, even parity, odd parity and two stop bits, all at
//             clksPerBit = 4. A FIFO queue feeds the active instance and the
//             expected line is derived from the frame layout.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_pull;

    localparam int CPB = 4;
    localparam int NI  = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [NI-1:0]   fifoE;
    logic [7:0]      din [NI];
    logic [NI-1:0]   readEn;
    logic [NI-1:0]   tx;
    logic [NI-1:0]   busy;
    logic [NI-1:0]   done;

    int              vectors = 0;
    int              miscompares = 0;
    logic [7:0]      fq[$];
    int              cur = 0;

    always #5 clk = ~clk;

    uart_tx_pull #(.dataBits(8), .clksPerBit(CPB), .parityMode(0), .stopBits(1)) u0 (
        .clk(clk), .reset(reset), .fifoE(fifoE[0]), .dataIn(din[0]),
        .readEn(readEn[0]), .tx(tx[0]), .txBusy(busy[0]), .txDone(done[0]));
    uart_tx_pull #(.dataBits(8), .clksPerBit(CPB), .parityMode(1), .stopBits(1)) u1 (
        .clk(clk), .reset(reset), .fifoE(fifoE[1]), .dataIn(din[1]),
        .readEn(readEn[1]), .tx(tx[1]), .txBusy(busy[1]), .txDone(done[1]));
    uart_tx_pull #(.dataBits(8), .clksPerBit(CPB), .parityMode(2), .stopBits(1)) u2 (
        .clk(clk), .reset(reset), .fifoE(fifoE[2]), .dataIn(din[2]),
        .readEn(readEn[2]), .tx(tx[2]), .txBusy(busy[2]), .txDone(done[2]));
    uart_tx_pull #(.dataBits(8), .clksPerBit(CPB), .parityMode(0), .stopBits(2)) u3 (
        .clk(clk), .reset(reset), .fifoE(fifoE[3]), .dataIn(din[3]),
        .readEn(readEn[3]), .tx(tx[3]), .txBusy(busy[3]), .txDone(done[3]));

    function automatic int pmode(input int k);
        return (k == 1) ? 1 : (k == 2) ? 2 : 0;
    endfunction

    function automatic int nstops(input int k);
        return (k == 3) ? 2 : 1;
    endfunction

    function automatic int flen(input int k);
        return (1 + 8 + ((pmode(k) != 0) ? 1 : 0) + nstops(k)) * CPB;
    endfunction

    // Level of bit slot b (0 = start) in the frame carrying word w.
    function automatic logic frame_bit(input int k, input logic [7:0] w, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return w[b-1];
        if (pmode(k) != 0 && b == 9) return (pmode(k) == 1) ? (^w) : ~(^w);
        return 1'b1;
    endfunction

    // Present the queue head to the active instance; every other data input
    // gets fresh noise each cycle.
    task automatic apply_fifo();
        for (int i = 0; i < NI; i++) begin
            fifoE[i] = 1'b1;
            din[i]   = 8'($urandom);
        end
        if (fq.size() > 0) begin
            fifoE[cur] = 1'b0;
            din[cur]   = fq[0];
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Sends everything in fq on instance k and checks every cycle until the
    // line is idle again. Entered 1 time unit after a rising edge.
    task automatic play(input int k);
        logic [7:0] w[$];
        int         nf, len, f, off;
        logic       pend, etx, ebusy, edone, erd;
        w   = fq;
        nf  = w.size();
        len = flen(k);
        cur = k;
        apply_fifo();
        #1;
        vectors++;
        if (readEn[k] !== (nf > 0)) begin
            miscompares++;
            $display("FAIL first_pop k=%0d got=%b exp=%b", k, readEn[k], (nf > 0));
        end
        pend = readEn[k];
        for (int c = 0; c < nf * len + 3; c++) begin
            @(posedge clk);
            #1;
            if (pend && fq.size() > 0) void'(fq.pop_front());
            apply_fifo();
            #1;
            f     = c / len;
            off   = c % len;
            etx   = (f < nf) ? frame_bit(k, w[f], off / CPB) : 1'b1;
            ebusy = (f < nf);
            edone = (c == nf * len);
            erd   = (f < nf - 1) && (off == len - 1);
            vectors++;
            if (tx[k] !== etx) begin
                miscompares++;
                $display("FAIL tx k=%0d cyc=%0d got=%b exp=%b", k, c, tx[k], etx);
            end
            vectors++;
            if (busy[k] !== ebusy) begin
                miscompares++;
                $display("FAIL txBusy k=%0d cyc=%0d got=%b exp=%b", k, c, busy[k], ebusy);
            end
            vectors++;
            if (done[k] !== edone) begin
                miscompares++;
                $display("FAIL txDone k=%0d cyc=%0d got=%b exp=%b", k, c, done[k], edone);
            end
            vectors++;
            if (readEn[k] !== erd) begin
                miscompares++;
                $display("FAIL readEn k=%0d cyc=%0d got=%b exp=%b", k, c, readEn[k], erd);
            end
            pend = readEn[k];
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        fifoE = '1;
        for (int i = 0; i < NI; i++) din[i] = 8'h00;
        #2;
        fifoE[0] = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                vectors++;
                if (tx[k] !== 1'b1 || busy[k] !== 1'b0 || done[k] !== 1'b0 || readEn[k] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL reset_state k=%0d got tx=%b busy=%b done=%b rd=%b exp 1000",
                             k, tx[k], busy[k], done[k], readEn[k]);
                end
            end
        end
        sync();
        fifoE = '1;
        reset = 1'b1;
        sync();
    endtask

    task automatic test_single();
        for (int k = 0; k < NI; k++) begin
            sync();
            fq = {8'hA5};
            play(k);
        end
    endtask

    task automatic test_back_to_back();
        sync();
        fq = {8'h00, 8'hFF, 8'h55};
        play(0);
        for (int k = 0; k < NI; k++) begin
            sync();
            fq.delete();
            for (int n = 0; n < 2 + int'($urandom_range(2)); n++) fq.push_back(8'($urandom));
            play(k);
        end
    endtask

    task automatic test_idle();
        sync();
        fq.delete();
        cur = 0;
        for (int n = 0; n < 100; n++) begin
            @(posedge clk);
            #1;
            apply_fifo();
            #1;
            for (int k = 0; k < NI; k++) begin
                vectors++;
                if (readEn[k] !== 1'b0 || tx[k] !== 1'b1 || busy[k] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL idle k=%0d got rd=%b tx=%b busy=%b exp 0 1 0",
                             k, readEn[k], tx[k], busy[k]);
                end
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] w0;
        logic       pend, etx;
        sync();
        w0  = 8'($urandom);
        fq  = {w0, 8'($urandom)};
        cur = 0;
        apply_fifo();
        #1;
        pend = readEn[0];
        for (int c = 0; c < 17; c++) begin
            @(posedge clk);
            #1;
            if (pend && fq.size() > 0) void'(fq.pop_front());
            apply_fifo();
            #1;
            etx = frame_bit(0, w0, c / CPB);
            vectors++;
            if (tx[0] !== etx) begin
                miscompares++;
                $display("FAIL rst_pre_tx cyc=%0d got=%b exp=%b", c, tx[0], etx);
            end
            pend = readEn[0];
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        vectors++;
        if (tx[0] !== 1'b1 || busy[0] !== 1'b0 || readEn[0] !== 1'b0 || done[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_abort got tx=%b busy=%b rd=%b done=%b exp 1000",
                     tx[0], busy[0], readEn[0], done[0]);
        end
        for (int n = 0; n < 2; n++) begin
            @(negedge clk);
            vectors++;
            if (tx[0] !== 1'b1 || readEn[0] !== 1'b0) begin
                miscompares++;
                $display("FAIL rst_hold got tx=%b rd=%b exp 1 0", tx[0], readEn[0]);
            end
        end
        vectors++;
        if (fq.size() != 1) begin
            miscompares++;
            $display("FAIL rst_queue got=%0d exp=1", fq.size());
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        play(0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            sync();
            fq.delete();
            for (int m = 0; m < 1 + int'($urandom_range(2)); m++) fq.push_back(8'($urandom));
            play(int'($urandom_range(NI - 1)));
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_idle();
        test_reset_midframe();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
